// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester byte-stream arbiter in front of the UART.
// Message-granular grant, round-robin, released on delimiter/burst/idle.
module uart_tx_arbiter #(
  parameter logic [7:0]  DELIM        = 8'h0A,
  parameter bit          DELIM_EN     = 1'b1,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] in0_data_i,
  input  logic       in0_valid_i,
  output logic       in0_ready_o,
  input  logic [7:0] in1_data_i,
  input  logic       in1_valid_i,
  output logic       in1_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        owner;
  logic        owner_nx;
  logic        last_owner;
  logic        last_owner_nx;
  logic [7:0]  byte_cnt;
  logic [7:0]  byte_cnt_nx;
  logic [15:0] idle_cnt;
  logic [15:0] idle_cnt_nx;
  logic [7:0]  data_nx;
  logic        valid_nx;

  logic        own_valid;
  logic [7:0]  own_data;
  logic        take;
  logic        hs;
  logic        locked;

  assign locked    = (state == LOCKED);
  assign own_valid = owner ? in1_valid_i : in0_valid_i;
  assign own_data  = owner ? in1_data_i : in0_data_i;
  assign take      = locked & (~out_valid_o | out_ready_i);
  assign hs        = take & own_valid;

  assign in0_ready_o = take & ~owner;
  assign in1_ready_o = take & owner;
  assign grant_o     = locked ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign timeout_o   = locked & ~own_valid & (idle_cnt == IDLE_LAST);

  // next-state: arbitration, byte capture, release and idle counting
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    byte_cnt_nx   = byte_cnt;
    idle_cnt_nx   = idle_cnt;
    data_nx       = out_data_o;
    valid_nx      = out_valid_o;
    if (out_valid_o & out_ready_i) begin
      valid_nx = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (in0_valid_i | in1_valid_i) begin
          state_nx      = LOCKED;
          owner_nx      = (in0_valid_i & in1_valid_i)
                        ? ~last_owner : in1_valid_i;
          last_owner_nx = owner_nx;
          byte_cnt_nx   = 8'd0;
          idle_cnt_nx   = 16'd0;
        end
      end
      LOCKED: begin
        if (hs) begin
          data_nx     = own_data;
          valid_nx    = 1'b1;
          idle_cnt_nx = 16'd0;
          if (byte_cnt != 8'hFF) begin
            byte_cnt_nx = byte_cnt + 8'd1;
          end
          if ((DELIM_EN && (own_data == DELIM)) ||
              (byte_cnt >= BURST_LAST)) begin
            state_nx = IDLE;
          end
        end else if (~own_valid) begin
          if (timeout_o) begin
            state_nx = IDLE;
          end else if (idle_cnt != 16'hFFFF) begin
            idle_cnt_nx = idle_cnt + 16'd1;
          end
        end
      end
    endcase
  end

  // state, owner and counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      byte_cnt   <= 8'd0;
      idle_cnt   <= 16'd0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      byte_cnt   <= byte_cnt_nx;
      idle_cnt   <= idle_cnt_nx;
    end
  end

  // output byte register toward the UART
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_data_o  <= 8'h00;
      out_valid_o <= 1'b0;
    end else begin
      out_data_o  <= data_nx;
      out_valid_o <= valid_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + random scoreboard bench.
// Per-requester queues model ordering; monitor tracks message segments.
module tb_uart_tx_arbiter;

  localparam logic [7:0] DELIM = 8'h0A;
  localparam int MAXB = 4;
  localparam int IDLE_TO = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       v0 = 1'b0;
  logic       in0_ready;
  logic [7:0] d1 = 8'h00;
  logic       v1 = 1'b0;
  logic       in1_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  uart_tx_arbiter #(
    .DELIM(DELIM),
    .DELIM_EN(1'b1),
    .MAX_BURST(MAXB),
    .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .in0_data_i(d0),
    .in0_valid_i(v0),
    .in0_ready_o(in0_ready),
    .in1_data_i(d1),
    .in1_valid_i(v1),
    .in1_ready_o(in1_ready),
    .out_data_o(out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .grant_o(grant),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int segs[$];
  int seg_src = -1;
  int seg_cnt = 0;
  int to_total = 0;
  bit rnd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic mon_byte(input logic [7:0] b);
    int s;
    int qs;
    logic [7:0] e;
    s = seg_src;
    if (s < 0) begin
      if (q0.size() > 0 && q0[0] == b) s = 0;
      else if (q1.size() > 0 && q1[0] == b) s = 1;
      if (s >= 0) begin
        segs.push_back(s);
        seg_cnt = 0;
      end
    end
    tests++;
    if (s < 0) begin
      fails++;
      $display("FAIL out_src: got %02h required head of q0/q1 (%0d/%0d)",
               b, q0.size(), q1.size());
    end else begin
      qs = (s == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        fails++;
        $display("FAIL out_extra src%0d: got %02h required nothing", s, b);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        if (e !== b) begin
          fails++;
          $display("FAIL out_order src%0d: got %02h required %02h", s, b, e);
        end
      end
      seg_cnt++;
      if (b == DELIM || seg_cnt == MAXB) seg_src = -1;
      else seg_src = s;
    end
  endtask

  // monitor: output handshakes and timeout pulses, sampled before posedge
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rstn && timeout) to_total++;
      if (rstn && out_valid && out_ready) mon_byte(out_data);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish required finish before 600us");
    $fatal(1);
  end

  task automatic send_byte(input int id, input logic [7:0] b);
    bit hs;
    int n;
    hs = 1'b0;
    n = 0;
    if (id == 0) begin
      d0 = b; v0 = 1'b1; q0.push_back(b);
    end else begin
      d1 = b; v1 = 1'b1; q1.push_back(b);
    end
    while (!hs) begin
      #4;
      hs = (id == 0) ? in0_ready : in1_ready;
      @(negedge clk);
      if (!hs) begin
        n++;
        if (n > 300) begin
          tests++;
          fails++;
          $display("FAIL send_wait src%0d byte %02h: got no ready required ready",
                   id, b);
          hs = 1'b1;
        end
      end
    end
  endtask

  task automatic drop(input int id);
    if (id == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic rnd_src(input int id);
    int len;
    logic [7:0] b;
    for (int m = 0; m < 10; m++) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        if (id == 0) b = 8'(32'h20 + $urandom_range(0, 31));
        else b = 8'(32'h40 + $urandom_range(0, 63));
        send_byte(id, b);
        if ($urandom_range(0, 3) == 0) begin
          drop(id);
          @(negedge clk);
        end
      end
      send_byte(id, DELIM);
      drop(id);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
    seg_src = -1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++)
      @(negedge clk);
  endtask

  int to_n;
  int to_at;

  initial begin
    // reset state
    @(negedge clk);
    #4;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_ready0", in0_ready, 0);
    chk("rst_ready1", in1_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    rstn = 1'b1;

    // single source "AB\n"
    @(negedge clk);
    d0 = 8'h41; v0 = 1'b1; q0.push_back(8'h41);
    #4 chk("t2_idle_grant", grant, 2'b00);
    @(negedge clk);
    #4 chk("t2_grant", grant, 2'b01);
    chk("t2_ready0", in0_ready, 1);
    @(negedge clk);
    d0 = 8'h42; q0.push_back(8'h42);
    #4 chk("t2_ov", out_valid, 1);
    chk("t2_d41", out_data, 8'h41);
    @(negedge clk);
    d0 = DELIM; q0.push_back(DELIM);
    #4 chk("t2_d42", out_data, 8'h42);
    @(negedge clk);
    v0 = 1'b0;
    #4 chk("t2_release", grant, 2'b00);
    chk("t2_d0a", out_data, DELIM);
    @(negedge clk);
    #4 chk("t2_ov_drop", out_valid, 0);

    // both valid from reset
    do_reset();
    @(negedge clk);
    d0 = 8'h58; v0 = 1'b1; q0.push_back(8'h58);
    d1 = 8'h59; v1 = 1'b1; q1.push_back(8'h59);
    #4 chk("t3_idle", grant, 2'b00);
    @(negedge clk);
    #4 chk("t3_grant0", grant, 2'b01);
    chk("t3_ready1_low", in1_ready, 0);
    @(negedge clk);
    d0 = DELIM; q0.push_back(DELIM);
    #4 chk("t3_hold0", grant, 2'b01);
    @(negedge clk);
    v0 = 1'b0;
    #4 chk("t3_gap", grant, 2'b00);
    @(negedge clk);
    #4 chk("t3_grant1", grant, 2'b10);
    @(negedge clk);
    d1 = DELIM; q1.push_back(DELIM);
    @(negedge clk);
    v1 = 1'b0;
    #4 chk("t3_end", grant, 2'b00);

    // idle timeout
    @(negedge clk);
    d0 = 8'h33; v0 = 1'b1; q0.push_back(8'h33);
    d1 = 8'h44; v1 = 1'b1; q1.push_back(8'h44);
    @(negedge clk);
    #4 chk("to_grant0", grant, 2'b01);
    @(negedge clk);
    v0 = 1'b0;
    to_n = 0;
    to_at = 0;
    for (int k = 1; k <= 17; k++) begin
      #4;
      if (timeout) begin
        to_n++;
        to_at = k;
      end
      if (k == 17) chk("to_idle", grant, 2'b00);
      @(negedge clk);
    end
    seg_src = -1;
    #4 chk("to_pulses", to_n, 1);
    chk("to_cycle", to_at, 16);
    chk("to_grant1", grant, 2'b10);
    @(negedge clk);
    d1 = DELIM; q1.push_back(DELIM);
    @(negedge clk);
    v1 = 1'b0;

    // burst limit, both streaming
    segs.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) send_byte(0, 8'(8'h10 + i));
        v0 = 1'b0;
      end
      begin
        for (int i = 0; i < 12; i++) send_byte(1, 8'(8'h80 + i));
        v1 = 1'b0;
      end
    join
    drain();
    chk("burst_segs", segs.size(), 6);
    for (int i = 0; i < segs.size(); i++)
      chk($sformatf("burst_seg%0d", i), segs[i], i % 2);

    // backpressure mid-message
    @(negedge clk);
    d0 = 8'h50; v0 = 1'b1; q0.push_back(8'h50);
    @(negedge clk);
    #4 chk("bp_grant", grant, 2'b01);
    @(negedge clk);
    d0 = 8'h51; q0.push_back(8'h51);
    @(negedge clk);
    d0 = 8'h52; q0.push_back(8'h52);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #4;
      chk("bp_ready0", in0_ready, 0);
      chk("bp_data", out_data, 8'h51);
      chk("bp_timeout", timeout, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #4 chk("bp_resume", in0_ready, 1);
    @(negedge clk);
    d0 = DELIM; q0.push_back(DELIM);
    @(negedge clk);
    v0 = 1'b0;
    #4 chk("bp_release", grant, 2'b00);
    drain();

    // async reset with a pending output byte
    @(negedge clk);
    d0 = 8'h21; v0 = 1'b1; q0.push_back(8'h21);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    v0 = 1'b0;
    #2 chk("ar_pending", out_valid, 1);
    rstn = 1'b0;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_grant", grant, 2'b00);
    chk("ar_ready0", in0_ready, 0);
    chk("ar_ready1", in1_ready, 0);
    repeat (3) @(negedge clk);
    q0.delete();
    q1.delete();
    seg_src = -1;
    rstn = 1'b1;
    out_ready = 1'b1;
    d0 = 8'h22; v0 = 1'b1; q0.push_back(8'h22);
    d1 = 8'h62; v1 = 1'b1; q1.push_back(8'h62);
    #4 chk("ar_idle", grant, 2'b00);
    @(negedge clk);
    #4 chk("ar_first_in0", grant, 2'b01);
    @(negedge clk);
    d0 = DELIM; q0.push_back(DELIM);
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    #4 chk("ar_then_in1", grant, 2'b10);
    @(negedge clk);
    d1 = DELIM; q1.push_back(DELIM);
    @(negedge clk);
    v1 = 1'b0;
    drain();

    // random traffic with random backpressure
    rnd_on = 1'b1;
    fork
      begin
        fork
          rnd_src(0);
          rnd_src(1);
        join
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    chk("timeout_total", to_total, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
